md_unit_param: RTL and testbench

Parametrised multiply/divide unit with private HI/LO registers for the E stage of the pipelined MIPS core. It replaces the fixed 32-bit MD block and adds configurable data width and latencies, multiply-accumulate operations (MADD/MADDU/MSUB/MSUBU), defined divide-by-zero and overflow results, and a `cancel` input that aborts an in-flight operation on a pipeline flush. Hazard logic stalls D-stage MD instructions while `busy` or `start` is high.

---
 rtl/md_unit_param.sv | 219 +++++++++++++++++++++
 tb/tb_md_unit_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_param.sv
// Multiply/divide unit with private HI/LO for the E stage: multi-cycle MULT/DIV/MADD/MSUB
// with configurable width and latencies, single-edge MTHI/MTLO and a flush cancel.
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;

    logic                 signed_mul_s;
    logic [2*WIDTH-1:0]   a_ext_s;
    logic [2*WIDTH-1:0]   b_ext_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   hilo_s;
    logic [2*WIDTH-1:0]   res_s;
    logic                 div_zero_s;
    logic                 div_ovf_s;
    logic [WIDTH-1:0]     sdiv_b_s;
    logic [WIDTH-1:0]     udiv_b_s;
    logic [WIDTH-1:0]     squot_s;
    logic [WIDTH-1:0]     srem_s;
    logic [WIDTH-1:0]     uquot_s;
    logic [WIDTH-1:0]     urem_s;

    function automatic logic is_long_op(input logic [3:0] code);
        case (code)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long_op = 1'b1;
            default:                              is_long_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] code);
        case (code)
            OP_DIV, OP_DIVU: is_div_op = 1'b1;
            default:         is_div_op = 1'b0;
        endcase
    endfunction

    // Divider operands: the divisor is forced to 1 for the special cases so the
    // arithmetic never divides by zero or overflows; those results are substituted below.
    always_comb begin
        div_zero_s = (b_r == W_ZERO);
        div_ovf_s  = (a_r == W_MIN) && (b_r == W_ONES);
        if (div_zero_s || div_ovf_s) begin
            sdiv_b_s = W_ONE;
        end else begin
            sdiv_b_s = b_r;
        end
        if (div_zero_s) begin
            udiv_b_s = W_ONE;
        end else begin
            udiv_b_s = b_r;
        end
        squot_s = $signed(a_r) / $signed(sdiv_b_s);
        srem_s  = $signed(a_r) % $signed(sdiv_b_s);
        uquot_s = a_r / udiv_b_s;
        urem_s  = a_r % udiv_b_s;
    end

    // Result to commit, computed from latched operands and the current HI/LO.
    always_comb begin
        case (op_r)
            OP_MULT, OP_MADD, OP_MSUB: signed_mul_s = 1'b1;
            default:                   signed_mul_s = 1'b0;
        endcase
        if (signed_mul_s) begin
            a_ext_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
            b_ext_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
        end else begin
            a_ext_s = {W_ZERO, a_r};
            b_ext_s = {W_ZERO, b_r};
        end
        prod_s = a_ext_s * b_ext_s;
        hilo_s = {hi_r, lo_r};
        case (op_r)
            OP_MULT, OP_MULTU: res_s = prod_s;
            OP_MADD, OP_MADDU: res_s = hilo_s + prod_s;
            OP_MSUB, OP_MSUBU: res_s = hilo_s - prod_s;
            OP_DIV: begin
                if (div_zero_s) begin
                    res_s = {a_r, W_ONES};
                end else if (div_ovf_s) begin
                    res_s = {W_ZERO, a_r};
                end else begin
                    res_s = {srem_s, squot_s};
                end
            end
            OP_DIVU: begin
                if (div_zero_s) begin
                    res_s = {a_r, W_ONES};
                end else begin
                    res_s = {urem_s, uquot_s};
                end
            end
            default: res_s = hilo_s;
        endcase
    end

    // Control FSM, operand latches and HI/LO; cancel outranks both start and commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            count_r <= CNT_ZERO;
            a_r     <= W_ZERO;
            b_r     <= W_ZERO;
            op_r    <= 4'd0;
            hi_r    <= W_ZERO;
            lo_r    <= W_ZERO;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cancel) begin
                        busy_r <= 1'b0;
                    end else if (start && is_long_op(op)) begin
                        a_r     <= A;
                        b_r     <= B;
                        op_r    <= op;
                        count_r <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                        busy_r  <= 1'b1;
                        state_r <= S_BUSY;
                    end else if (start && (op == OP_MTHI)) begin
                        hi_r <= A;
                    end else if (start && (op == OP_MTLO)) begin
                        lo_r <= A;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (cancel) begin
                        count_r <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (count_r == CNT_ONE) begin
                        hi_r    <= res_s[2*WIDTH-1:WIDTH];
                        lo_r    <= res_s[WIDTH-1:0];
                        count_r <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end
                default: begin
                    count_r <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // MF* read port: combinational so the E stage sees HI/LO with no latency.
    always_comb begin
        case (op)
            OP_MFHI: out = hi_r;
            OP_MFLO: out = lo_r;
            default: out = W_ZERO;
        endcase
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: directed vectors plus random operations checked against an
// arithmetic model, on a 32-bit instance and an 8-bit single-cycle-multiply instance.
module tb_md_unit_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        cancel;
    logic        start32, start8;
    logic [3:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, busy8;
    logic [31:0] hi32, lo32, out32;
    logic [7:0]  hi8, lo8, out8;

    int checks = 0;
    int errors = 0;
    logic [63:0] hi_m [2];
    logic [63:0] lo_m [2];

    always #5 clk = ~clk;

    md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .cancel(cancel),
        .A(a32), .B(b32), .busy(busy32), .HI(hi32), .LO(lo32), .out(out32)
    );

    md_unit_param #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .cancel(cancel),
        .A(a8), .B(b8), .busy(busy8), .HI(hi8), .LO(lo8), .out(out8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {HI,LO} packed as HI<<w | LO, from plain integer arithmetic.
    function automatic logic [63:0] model(input int w, input int op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] hi,
                                          input logic [63:0] lo);
        logic [63:0] mask, m2, hilo, r;
        longint base, sa, sb, q, rm;
        mask = (64'd1 << w) - 64'd1;
        m2   = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        base = longint'(64'd1 << w);
        sa   = a[w-1] ? longint'(a) - base : longint'(a);
        sb   = b[w-1] ? longint'(b) - base : longint'(b);
        hilo = (hi << w) | lo;
        case (op)
            1:  r = sa * sb;
            2:  r = a * b;
            9:  r = hilo + (sa * sb);
            10: r = hilo + (a * b);
            11: r = hilo - (sa * sb);
            12: r = hilo - (a * b);
            3: begin
                if (b == 64'd0) r = (a << w) | mask;
                else if (a == (64'd1 << (w - 1)) && b == mask) r = a;
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = ((rm & mask) << w) | (q & mask);
                end
            end
            4: begin
                if (b == 64'd0) r = (a << w) | mask;
                else r = ((a % b) << w) | (a / b);
            end
            default: r = hilo;
        endcase
        return r & m2;
    endfunction

    task automatic drive(input int d, input logic s, input int o, input logic [31:0] a,
                         input logic [31:0] b);
        if (d == 1) begin
            start8 = s; op8 = o[3:0]; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = o[3:0]; a32 = a; b32 = b;
        end
    endtask

    function automatic logic cur_busy(input int d);
        return (d == 1) ? busy8 : busy32;
    endfunction
    function automatic logic [63:0] cur_hi(input int d);
        return (d == 1) ? {56'd0, hi8} : {32'd0, hi32};
    endfunction
    function automatic logic [63:0] cur_lo(input int d);
        return (d == 1) ? {56'd0, lo8} : {32'd0, lo32};
    endfunction
    function automatic logic [63:0] cur_out(input int d);
        return (d == 1) ? {56'd0, out8} : {32'd0, out32};
    endfunction

    // Issue one multi-cycle op at a negedge, measure busy length, check HI/LO and MF* reads.
    task automatic run_op(input int d, input int op, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy);
        int w, n, n_exp;
        logic [63:0] mask, am, bm, r;
        w     = (d == 1) ? 8 : 32;
        mask  = (64'd1 << w) - 64'd1;
        am    = {32'd0, a} & mask;
        bm    = {32'd0, b} & mask;
        n_exp = (op == 3 || op == 4) ? ((d == 1) ? 3 : 10) : ((d == 1) ? 1 : 5);
        r     = model(w, op, am, bm, hi_m[d], lo_m[d]);
        drive(d, 1'b1, op, am[31:0], bm[31:0]);
        @(negedge clk);
        drive(d, 1'b0, 0, am[31:0], bm[31:0]);
        n = 0;
        while (cur_busy(d) === 1'b1 && n < 200) begin
            n++;
            if (noisy) drive(d, 1'($urandom % 2), $urandom_range(1, 12), $urandom, $urandom);
            @(negedge clk);
        end
        drive(d, 1'b0, 0, 32'd0, 32'd0);
        hi_m[d] = (r >> w) & mask;
        lo_m[d] = r & mask;
        check("busy_len", 64'(n), 64'(n_exp));
        check("hi", cur_hi(d), hi_m[d]);
        check("lo", cur_lo(d), lo_m[d]);
        drive(d, 1'b0, 6, 32'd0, 32'd0);
        #1 check("out_mflo", cur_out(d), lo_m[d]);
        drive(d, 1'b0, 5, 32'd0, 32'd0);
        #1 check("out_mfhi", cur_out(d), hi_m[d]);
        drive(d, 1'b0, 0, 32'd0, 32'd0);
        #1 check("out_none", cur_out(d), 64'd0);
    endtask

    task automatic mt(input int d, input int op, input logic [31:0] a);
        logic [63:0] mask;
        mask = (d == 1) ? 64'hFF : 64'hFFFF_FFFF;
        drive(d, 1'b1, op, a, 32'd0);
        @(negedge clk);
        drive(d, 1'b0, 0, 32'd0, 32'd0);
        if (op == 7) hi_m[d] = {32'd0, a} & mask;
        else lo_m[d] = {32'd0, a} & mask;
        check("mt_busy", 64'(cur_busy(d)), 64'd0);
        check("mt_hi", cur_hi(d), hi_m[d]);
        check("mt_lo", cur_lo(d), lo_m[d]);
    endtask

    initial begin
        int ops [10];
        int o;
        logic [31:0] ra, rb;
        logic [63:0] h_save, l_save;
        ops = '{1, 2, 3, 4, 9, 10, 11, 12, 7, 8};
        reset = 1'b0;
        cancel = 1'b0;
        drive(0, 1'b0, 0, 32'd0, 32'd0);
        drive(1, 1'b0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            hi_m[i] = 64'd0;
            lo_m[i] = 64'd0;
        end
        #12;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_hi", 64'(hi32), 64'd0);
        check("rst_lo", 64'(lo32), 64'd0);
        check("rst_out", 64'(out32), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(0, 1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("vec_mult_hi", 64'(hi32), 64'hFFFF_FFFF);
        check("vec_mult_lo", 64'(lo32), 64'hFFFF_FFFA);
        run_op(0, 3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("vec_div_lo", 64'(lo32), 64'hFFFF_FFFD);
        check("vec_div_hi", 64'(hi32), 64'hFFFF_FFFF);
        run_op(0, 4, 32'd7, 32'd0, 1'b0);
        check("vec_div0_lo", 64'(lo32), 64'hFFFF_FFFF);
        check("vec_div0_hi", 64'(hi32), 64'd7);
        run_op(0, 3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("vec_ovf_lo", 64'(lo32), 64'h8000_0000);
        check("vec_ovf_hi", 64'(hi32), 64'd0);
        mt(0, 7, 32'd0);
        mt(0, 8, 32'hFFFF_FFFF);
        run_op(0, 10, 32'd1, 32'd1, 1'b0);
        check("vec_maddu_hi", 64'(hi32), 64'd1);
        check("vec_maddu_lo", 64'(lo32), 64'd0);
        run_op(0, 11, 32'd1, 32'd1, 1'b0);
        check("vec_msub_hi", 64'(hi32), 64'd0);
        check("vec_msub_lo", 64'(lo32), 64'hFFFF_FFFF);

        // Cancel in busy cycle 4 of a DIVU, with a same-cycle MULT start.
        h_save = hi_m[0];
        l_save = lo_m[0];
        drive(0, 1'b1, 4, 32'd100, 32'd7);
        @(negedge clk);
        drive(0, 1'b0, 0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("cancel_pre_busy", 64'(busy32), 64'd1);
        cancel = 1'b1;
        drive(0, 1'b1, 1, 32'd5, 32'd6);
        @(negedge clk);
        cancel = 1'b0;
        drive(0, 1'b0, 0, 32'd0, 32'd0);
        check("cancel_busy", 64'(busy32), 64'd0);
        check("cancel_hi", 64'(hi32), h_save);
        check("cancel_lo", 64'(lo32), l_save);
        repeat (6) @(negedge clk);
        check("cancel_no_mult_busy", 64'(busy32), 64'd0);
        check("cancel_no_mult_lo", 64'(lo32), l_save);

        // Cancel in idle suppresses MTHI.
        cancel = 1'b1;
        drive(0, 1'b1, 7, 32'h5A5A_5A5A, 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        drive(0, 1'b0, 0, 32'd0, 32'd0);
        check("cancel_mthi", 64'(hi32), h_save);

        run_op(0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_op(0, 3, 32'h8765_4321, 32'h0000_1234, 1'b1);

        for (int i = 0; i < 24; i++) begin
            o  = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (o == 7 || o == 8) mt(0, o, ra);
            else run_op(0, o, ra, rb, 1'b0);
        end

        run_op(1, 1, 32'hFE, 32'd3, 1'b0);
        check("vec8_hi", 64'(hi8), 64'hFF);
        check("vec8_lo", 64'(lo8), 64'hFA);
        for (int i = 0; i < 16; i++) begin
            o  = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (o == 7 || o == 8) mt(1, o, ra);
            else run_op(1, o, ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of a DIV.
        mt(0, 7, 32'h0000_1234);
        mt(0, 8, 32'h0000_5678);
        drive(0, 1'b1, 3, 32'd1000, 32'd3);
        @(negedge clk);
        drive(0, 1'b0, 0, 32'd0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_hi", 64'(hi32), 64'd0);
        check("arst_lo", 64'(lo32), 64'd0);
        for (int i = 0; i < 2; i++) begin
            hi_m[i] = 64'd0;
            lo_m[i] = 64'd0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
